// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: two-entry (main + skid) elastic stage register for the P7 MIPS core.
// Optional perf counters are built only when PIPE_SKID_PERF_EN is defined.
module pipe_skid_reg #(
  parameter int          SIDE_W   = 64,
  parameter logic [31:0] RESET_PC = 32'h3000,
  parameter logic [31:0] REQ_PC   = 32'h4180,
  parameter int          CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Req,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       PC_in,
  input  logic [31:0]       Instr_in,
  input  logic [4:0]        ExcCode_in,
  input  logic              BD_in,
  input  logic [SIDE_W-1:0] side_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       PC_out,
  output logic [31:0]       Instr_out,
  output logic [4:0]        ExcCode_out,
  output logic              BD_out,
  output logic [SIDE_W-1:0] side_out,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef struct packed {
    logic [31:0]       pc;
    logic [31:0]       instr;
    logic [4:0]        exc_code;
    logic              bd;
    logic [SIDE_W-1:0] side;
  } payload_t;

  payload_t r_main;
  payload_t r_skid;
  payload_t w_in;
  logic     r_main_valid;
  logic     r_skid_valid;
  logic     w_accept;
  logic     w_drain;

  always_comb begin
    // NOTE: give every always_comb target a default first; a path that skips it infers a latch.
    w_in          = '0;
    w_in.pc       = PC_in;
    w_in.instr    = Instr_in;
    w_in.exc_code = ExcCode_in;
    w_in.bd       = BD_in;
    w_in.side     = side_in;
  end

  // in_ready comes straight from a flop, so out_ready never reaches upstream combinationally.
  assign w_accept = in_valid && !r_skid_valid;
  assign w_drain  = r_main_valid && out_ready;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_main       <= '{pc: RESET_PC, instr: '0, exc_code: '0, bd: 1'b0, side: '0};
    end else if (Req) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_main       <= '{pc: REQ_PC, instr: '0, exc_code: '0, bd: 1'b0, side: '0};
    end else if (flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_main       <= '{pc: r_main.pc, instr: '0, exc_code: '0, bd: 1'b0, side: '0};
    end else if (r_skid_valid) begin
      if (w_drain) begin
        r_main       <= r_skid;
        r_main_valid <= 1'b1;
        r_skid_valid <= 1'b0;
      end
    end else if (!r_main_valid || w_drain) begin
      r_main_valid <= w_accept;
      if (w_accept) r_main <= w_in;
    end else if (w_accept) begin
      r_skid_valid <= 1'b1;
    end
  end

  // NOTE: the skid payload is pure datapath with no reset; r_skid_valid alone qualifies it.
  always_ff @(posedge clk) begin
    if (!r_skid_valid) r_skid <= w_in;
  end

  assign in_ready    = !r_skid_valid;
  assign out_valid   = r_main_valid;
  assign occupancy   = {r_skid_valid, r_main_valid & ~r_skid_valid};
  assign PC_out      = r_main.pc;
  assign Instr_out   = r_main.instr;
  assign ExcCode_out = r_main.exc_code;
  assign BD_out      = r_main.bd;
  assign side_out    = r_main.side;

`ifdef PIPE_SKID_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_bubble_cnt;

  // Counters observe the stage as seen this cycle, so Req/flush do not disturb them.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (r_main_valid && !out_ready && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (!r_main_valid && (r_bubble_cnt != '1))
        r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

  a_skid_needs_main: assert property (@(posedge clk) disable iff (reset)
    r_skid_valid |-> r_main_valid);

  a_kill_empties: assert property (@(posedge clk) disable iff (reset)
    (Req || flush) |=> (!r_main_valid && !r_skid_valid));

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: queue-based reference model checked every cycle plus literal spot checks.
module tb_pipe_skid_reg;
  localparam int SIDE_W = 64;
  localparam int CNT_W  = 32;
`ifdef PIPE_SKID_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset, Req, flush, in_valid, in_ready, out_valid, out_ready, BD_in, BD_out;
  logic [31:0]       PC_in, Instr_in, PC_out, Instr_out;
  logic [4:0]        ExcCode_in, ExcCode_out;
  logic [SIDE_W-1:0] side_in, side_out;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt, bubble_cnt;

  always #5 clk = ~clk;

  pipe_skid_reg dut (
    .clk(clk), .reset(reset), .Req(Req), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .PC_in(PC_in), .Instr_in(Instr_in), .ExcCode_in(ExcCode_in), .BD_in(BD_in), .side_in(side_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .PC_out(PC_out), .Instr_out(Instr_out), .ExcCode_out(ExcCode_out), .BD_out(BD_out),
    .side_out(side_out), .occupancy(occupancy), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  typedef struct {
    logic [31:0]       pc;
    logic [31:0]       instr;
    logic [4:0]        exc;
    logic              bd;
    logic [SIDE_W-1:0] side;
  } pl_t;

  pl_t              m_q[$];
  pl_t              m_shown;
  logic [CNT_W-1:0] m_stall, m_bubble;
  bit               m_ready = 1'b0;
  bit               done = 1'b0;
  int               n_checks = 0;
  int               n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic pl_t blank_pl(input logic [31:0] pc);
    pl_t p;
    p.pc = pc; p.instr = '0; p.exc = '0; p.bd = 1'b0; p.side = '0;
    return p;
  endfunction

  // Reference: a FIFO of at most two items; the front is shown, and the last shown payload lingers.
  task automatic model_step();
    pl_t inc;
    bit  acc, drn;
    inc.pc = PC_in; inc.instr = Instr_in; inc.exc = ExcCode_in; inc.bd = BD_in; inc.side = side_in;
    if (reset) begin
      m_q.delete();
      m_shown  = blank_pl(32'h3000);
      m_stall  = '0;
      m_bubble = '0;
      m_ready  = 1'b1;
      return;
    end
    if (!m_ready) return;
    if (m_q.size() == 0) m_bubble++;
    else if (!out_ready) m_stall++;
    if (Req) begin
      m_q.delete();
      m_shown = blank_pl(32'h4180);
    end else if (flush) begin
      m_q.delete();
      m_shown = blank_pl(m_shown.pc);
    end else begin
      acc = in_valid && (m_q.size() < 2);
      drn = (m_q.size() > 0) && out_ready;
      if (drn) void'(m_q.pop_front());
      if (acc) m_q.push_back(inc);
      if (m_q.size() > 0) m_shown = m_q[0];
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (m_ready && !done) begin
      check("out_valid", 64'(out_valid), 64'(m_q.size() > 0));
      check("in_ready", 64'(in_ready), 64'(m_q.size() < 2));
      check("occupancy", 64'(occupancy), 64'(m_q.size()));
      check("PC_out", 64'(PC_out), 64'(m_shown.pc));
      check("Instr_out", 64'(Instr_out), 64'(m_shown.instr));
      check("ExcCode_out", 64'(ExcCode_out), 64'(m_shown.exc));
      check("BD_out", 64'(BD_out), 64'(m_shown.bd));
      check("side_out", side_out, m_shown.side);
      check("stall_cnt", 64'(stall_cnt), PERF ? 64'(m_stall) : 64'd0);
      check("bubble_cnt", 64'(bubble_cnt), PERF ? 64'(m_bubble) : 64'd0);
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic send(input logic [31:0] pc);
    in_valid   = 1'b1;
    PC_in      = pc;
    Instr_in   = pc ^ 32'hA5A5_0000;
    ExcCode_in = pc[6:2];
    BD_in      = pc[2];
    side_in    = {~pc, pc};
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  logic [23:0] vpat = 24'b1101_1110_0111_1011_1111_0110;
  logic [23:0] rpat = 24'b0110_0011_1101_1000_1111_1010;
  logic [31:0] pc_next;

  initial begin
    reset = 1'b1; Req = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_valid = 1'b0; PC_in = '0; Instr_in = '0; ExcCode_in = '0; BD_in = 1'b0; side_in = '0;
    cyc(); cyc();
    check("rst_pc", 64'(PC_out), 64'h3000);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_occ", 64'(occupancy), 64'd0);
    reset = 1'b0;
    repeat (5) cyc();
    check("idle_bubble", 64'(bubble_cnt), PERF ? 64'd5 : 64'd0);

    // Streaming with downstream always ready
    out_ready = 1'b1;
    send(32'h3000); cyc();
    check("st_valid", 64'(out_valid), 64'd1);
    check("st_pc0", 64'(PC_out), 64'h3000);
    send(32'h3004); cyc();
    check("st_pc1", 64'(PC_out), 64'h3004);
    send(32'h3008); cyc();
    check("st_pc2", 64'(PC_out), 64'h3008);
    check("st_instr2", 64'(Instr_out), 64'hA5A5_3008);
    idle(); cyc();
    check("st_drained", 64'(out_valid), 64'd0);
    check("st_held_pc", 64'(PC_out), 64'h3008);

    // Back-pressure fills the skid entry
    out_ready = 1'b0;
    send(32'h3000); cyc();
    send(32'h3004); cyc();
    idle();
    check("bp_occ", 64'(occupancy), 64'd2);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    check("bp_pc", 64'(PC_out), 64'h3000);
    out_ready = 1'b1; cyc();
    check("bp_pc_next", 64'(PC_out), 64'h3004);
    check("bp_ready_back", 64'(in_ready), 64'd1);
    check("bp_occ1", 64'(occupancy), 64'd1);
    cyc();
    check("bp_empty", 64'(occupancy), 64'd0);

    // Req while skid is full, with a concurrent input that must be dropped
    out_ready = 1'b0;
    send(32'h3008); cyc();
    send(32'h300C); cyc();
    check("rq_full", 64'(occupancy), 64'd2);
    Req = 1'b1; send(32'h3010); cyc();
    Req = 1'b0; idle();
    check("rq_valid", 64'(out_valid), 64'd0);
    check("rq_pc", 64'(PC_out), 64'h4180);
    check("rq_instr", 64'(Instr_out), 64'd0);
    check("rq_occ", 64'(occupancy), 64'd0);
    check("rq_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1; cyc(); cyc();
    check("rq_no_ghost", 64'(PC_out), 64'h4180);

    // Req beats flush; flush alone keeps the PC
    out_ready = 1'b0;
    send(32'h3020); cyc(); idle();
    check("rf_loaded", 64'(PC_out), 64'h3020);
    Req = 1'b1; flush = 1'b1; cyc();
    Req = 1'b0; flush = 1'b0;
    check("rf_req_wins", 64'(PC_out), 64'h4180);
    send(32'h3020); cyc(); idle();
    flush = 1'b1; cyc(); flush = 1'b0;
    check("fl_pc", 64'(PC_out), 64'h3020);
    check("fl_instr", 64'(Instr_out), 64'd0);
    check("fl_exc", 64'(ExcCode_out), 64'd0);
    check("fl_valid", 64'(out_valid), 64'd0);

    // Mixed valid/ready patterns, checked by the model every cycle
    pc_next = 32'h3100;
    for (int i = 0; i < 24; i++) begin
      out_ready = rpat[i];
      if (vpat[i]) begin
        send(pc_next);
        pc_next = pc_next + 32'd4;
      end else begin
        idle();
      end
      cyc();
    end
    idle(); out_ready = 1'b1; cyc(); cyc(); cyc();

    // Stall counting and reset in the middle of a stall
    reset = 1'b1; cyc(); reset = 1'b0;
    out_ready = 1'b0;
    send(32'h3030); cyc(); idle();
    repeat (3) cyc();
    check("pf_stall3", 64'(stall_cnt), PERF ? 64'd3 : 64'd0);
    reset = 1'b1; cyc();
    check("pf_stall_clr", 64'(stall_cnt), 64'd0);
    check("pf_occ_clr", 64'(occupancy), 64'd0);
    check("pf_valid_clr", 64'(out_valid), 64'd0);
    reset = 1'b0; cyc();

    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Parametrised elastic pipeline-stage register for the P7 MIPS core. It replaces the plain enable-gated stage register with a two-entry (main + skid) buffer carrying PC, Instr, ExcCode, BD and a generic sideband, under a valid/ready handshake. It supports pipeline flush and exception-request override. It sits between any two pipeline stages (F/D, D/E, E/M, M/W), so upstream never sees a combinational path from out_ready.

## Interface
- SIDE_W, 64, sideband width (e.g. check/set pair)
- RESET_PC, 32'h3000, PC_out value after reset
- REQ_PC, 32'h4180, PC_out value loaded on exception request
- CNT_W, 32, perf counter width
- clk  in  1  single clock; one clock; all state updates on posedge clk
- reset  in  1  synchronous, active-high
- Req  in  1  exception request; highest priority after reset
- flush  in  1  discard both entries (bubble)
- in_valid  in  1  upstream payload valid
- in_ready  out  1  stage can accept; equals !skid_valid (registered source only)
- PC_in / Instr_in  in  32 each  payload
- ExcCode_in  in  5  payload
- BD_in  in  1  payload
- side_in  in  SIDE_W  payload
- out_valid  out  1  main entry valid
- out_ready  in  1  downstream accepts
- PC_out / Instr_out / ExcCode_out / BD_out / side_out  out  as inputs  main-entry payload
- occupancy  out  2  number of valid entries (0..2)
- stall_cnt  out  CNT_W  perf: stalled cycles
- bubble_cnt  out  CNT_W  perf: empty cycles

## Operation
- Priority per cycle: reset > Req > flush > normal handshake.
- Reset: out_valid=0, skid invalid, PC_out=RESET_PC, Instr_out=0, ExcCode_out=0, BD_out=0, side_out=0, occupancy=0, in_ready=1, counters=0.
- Req: both entries invalid. Main payload becomes PC=REQ_PC, Instr=0, ExcCode=0, BD=0, side=0. Any concurrent input is dropped.
- flush: both entries invalid. Main PC retained, so macroscopic PC stays visible; Instr/ExcCode/BD/side cleared to 0. Any concurrent input handshake is dropped.
- Normal operation, with accept = in_valid && in_ready and drain = out_valid && out_ready:
  - main empty or drain, skid empty: main <= input if accept, else main invalid (payload held).
  - main full, no drain, accept: skid <= input.
  - drain, skid full: main <= skid, skid invalid. in_ready was 0, so no accept this cycle.
  - no drain, no accept: hold.
- Invalid main keeps the last payload on its outputs; only out_valid drops.
- Data order is strictly FIFO. No entry is ever duplicated or lost except by Req/flush.

## Timing
- Latency in_valid→out_valid: 1 cycle when empty.
- Throughput: 1 transfer/cycle sustained while out_ready=1.
- in_ready is a pure register output. out_ready has no combinational path to in_ready.
- occupancy, out_valid and in_ready update in the cycle after the causing edge.
- Req/flush take effect at the same posedge they are sampled. The stage is empty (occupancy=0, in_ready=1) in the following cycle.
- Req/flush asserted with skid full: both entries lost, in_ready returns to 1 next cycle.

## Configuration
- PIPE_SKID_PERF_EN defined:
  - stall_cnt increments each cycle with out_valid && !out_ready.
  - bubble_cnt increments each cycle with !out_valid.
  - Both saturate at all-ones, clear on reset only, and are unaffected by Req/flush.
- PIPE_SKID_PERF_EN undefined: counter logic is absent; stall_cnt and bubble_cnt are tied to 0. Ports remain.

## Test plan
- Reset then idle: PC_out=32'h3000, out_valid=0, in_ready=1, occupancy=0. With perf enabled, bubble_cnt=5 after 5 idle cycles.
- Stream PC 0x3000,0x3004,0x3008 with out_ready=1: out_valid rises 1 cycle after the first in_valid, and outputs appear in order one per cycle.
- Hold out_ready=0 and send 0x3000, 0x3004: occupancy=2, in_ready=0, PC_out=0x3000. Raising out_ready drains 0x3000 then 0x3004 on consecutive cycles; in_ready=1 the cycle after skid empties.
- Skid full, assert Req with in_valid=1 PC_in=0x3010: next cycle out_valid=0, PC_out=0x4180, Instr_out=0, occupancy=0, in_ready=1, and 0x3010 is never emitted.
- Req and flush in the same cycle with main PC=0x3020: Req wins, so PC_out=0x4180. Flush alone instead: PC_out stays 0x3020, Instr_out=0, out_valid=0.
- Perf build: 3 cycles out_valid=1 with out_ready=0 gives stall_cnt=3. Reset mid-stall clears it to 0 and the stage to empty.
